// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory port between instruction fetch and data accesses.
// Data has priority, fetch is protected from starvation, and stuck accesses are aborted with err.
module mem_port_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_flush,
  output logic        if_ready,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [2:0]  d_ubhw,
  output logic        d_ready,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [2:0]  mem_ubhw,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        owner
);
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, RESP = 2'd2} state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  localparam logic [7:0] TMO_LIM    = 8'(TIMEOUT);
  localparam logic [2:0] FETCH_UBHW = 3'b010;

  state_t      state_q, state_d;
  logic [3:0]  starve_q, starve_d;
  logic [7:0]  tmo_q, tmo_d;
  logic        owner_q, owner_d;
  logic        flushed_q, flushed_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [2:0]  mem_ubhw_q, mem_ubhw_d;
  logic        if_ready_q, if_ready_d, if_err_q, if_err_d;
  logic        d_ready_q, d_ready_d, d_err_q, d_err_d;
  logic [31:0] if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
  logic        eff_if, grant_if, resp_now, resp_err;
  logic [31:0] resp_rdata;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v >= STARVE_LIM) ? STARVE_LIM : v + 4'd1;
  endfunction

  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    tmo_d       = tmo_q;
    owner_d     = owner_q;
    flushed_d   = flushed_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_ubhw_d  = mem_ubhw_q;
    if_ready_d  = 1'b0;
    if_err_d    = if_err_q;
    if_rdata_d  = if_rdata_q;
    d_ready_d   = 1'b0;
    d_err_d     = d_err_q;
    d_rdata_d   = d_rdata_q;
    eff_if      = if_req & ~if_flush;
    grant_if    = 1'b0;
    resp_now    = 1'b0;
    resp_err    = 1'b0;
    resp_rdata  = '0;

    case (state_q)
      IDLE: begin
        if (d_req || eff_if) begin
          grant_if    = eff_if & (~d_req | (starve_q == STARVE_LIM));
          owner_d     = ~grant_if;
          mem_req_d   = 1'b1;
          mem_we_d    = grant_if ? 1'b0 : d_we;
          mem_addr_d  = grant_if ? if_addr : d_addr;
          mem_wdata_d = grant_if ? mem_wdata_q : d_wdata;
          mem_ubhw_d  = grant_if ? FETCH_UBHW : d_ubhw;
          flushed_d   = 1'b0;
          tmo_d       = '0;
          state_d     = ISSUE;
          if (grant_if) starve_d = '0;
          else if (eff_if) starve_d = sat_inc(starve_q);
        end
      end
      ISSUE: begin
        tmo_d = tmo_q + 8'd1;
        if (!owner_q && if_flush) flushed_d = 1'b1;
        // An ack in the timeout cycle still counts as a good completion.
        if (mem_ack) begin
          resp_now   = 1'b1;
          resp_rdata = mem_rdata;
        end else if (tmo_d == TMO_LIM) begin
          resp_now = 1'b1;
          resp_err = 1'b1;
        end
        if (resp_now) begin
          mem_req_d = 1'b0;
          state_d   = RESP;
          if (owner_q) begin
            d_ready_d = 1'b1;
            d_rdata_d = resp_rdata;
            d_err_d   = resp_err;
          end else if (!(flushed_q || if_flush)) begin
            if_ready_d = 1'b1;
            if_rdata_d = resp_rdata;
            if_err_d   = resp_err;
          end
        end
      end
      RESP: begin
        tmo_d     = '0;
        flushed_d = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      tmo_q       <= '0;
      owner_q     <= 1'b0;
      flushed_q   <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_ubhw_q  <= '0;
      if_ready_q  <= 1'b0;
      if_err_q    <= 1'b0;
      if_rdata_q  <= '0;
      d_ready_q   <= 1'b0;
      d_err_q     <= 1'b0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      tmo_q       <= tmo_d;
      owner_q     <= owner_d;
      flushed_q   <= flushed_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_ubhw_q  <= mem_ubhw_d;
      if_ready_q  <= if_ready_d;
      if_err_q    <= if_err_d;
      if_rdata_q  <= if_rdata_d;
      d_ready_q   <= d_ready_d;
      d_err_q     <= d_err_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign if_ready  = if_ready_q;
  assign if_rdata  = if_rdata_q;
  assign if_err    = if_err_q;
  assign d_ready   = d_ready_q;
  assign d_rdata   = d_rdata_q;
  assign d_err     = d_err_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_ubhw  = mem_ubhw_q;
  assign owner     = owner_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, corner-case sequences, and a randomized
// phase checked against a transaction-level arbitration/response model.
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0, if_flush = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_ready, if_err;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0, d_we = 1'b0;
  logic [31:0] d_addr = '0, d_wdata = '0;
  logic [2:0]  d_ubhw = '0;
  logic        d_ready, d_err;
  logic [31:0] d_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [2:0]  mem_ubhw;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        owner;

  always #5 clk = ~clk;

  mem_port_arbiter #(.STARVE_MAX(4), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_ready(if_ready), .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ubhw(d_ubhw),
    .d_ready(d_ready), .d_rdata(d_rdata), .d_err(d_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ubhw(mem_ubhw), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .owner(owner)
  );

  int errors = 0, checks = 0, cyc = 0;
  logic [31:0] mem [0:255];
  int cur_lat = 0, ack_wait = 0, ack_cnt = 0;
  int if_ready_cnt = 0, d_ready_cnt = 0;
  logic [31:0] last_if_rdata = '0, last_d_rdata = '0;
  logic last_if_err = 1'b0, last_d_err = 1'b0;

  // transaction-level reference model state
  bit mon_en = 1'b0, outst = 1'b0, m_owner = 1'b0, m_err = 1'b0;
  int starve_m = 0, exp_cyc = 0, nresp = 0;
  logic [31:0] m_rdata = '0;

  typedef struct {
    bit is_d; bit we; logic [31:0] addr; logic [31:0] wdata; int lat;
    logic [31:0] exp_rdata; logic exp_err; int exp_cyc; int exp_req;
  } vec_t;
  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic model_step(input bit drv_if, input bit drv_d, input bit prev_req);
    logic [31:0] a;
    bit w;
    if (mem_req && !prev_req) begin
      check("grant_had_req", 32'(drv_if | drv_d), 32'd1);
      w = drv_d && !(drv_if && starve_m == 4);
      check("grant_owner", 32'(owner), 32'(w));
      a = w ? d_addr : if_addr;
      check("grant_addr", mem_addr, a);
      check("grant_we", 32'(mem_we), 32'(w & d_we));
      if (w) check("grant_ubhw", 32'(mem_ubhw), 32'(d_ubhw));
      if (w && d_we) check("grant_wdata", mem_wdata, d_wdata);
      if (!w) starve_m = 0;
      else if (drv_if && starve_m < 4) starve_m++;
      cur_lat = ($urandom_range(0, 7) == 0) ? 20 : int'($urandom_range(0, 4));
      m_err   = (cur_lat >= 16);
      m_rdata = (m_err || (w && d_we)) ? 32'd0 : mem[a[9:2]];
      m_owner = w;
      exp_cyc = cyc + (m_err ? 16 : cur_lat + 1);
      outst   = 1'b1;
    end
    if (if_ready || d_ready) begin
      check("resp_outstanding", 32'(outst), 32'd1);
      check("resp_port", 32'(d_ready), 32'(m_owner));
      check("resp_rdata", d_ready ? d_rdata : if_rdata, m_rdata);
      check("resp_err", 32'(d_ready ? d_err : if_err), 32'(m_err));
      check("resp_cycle", 32'(cyc), 32'(exp_cyc));
      outst = 1'b0;
      nresp++;
    end else if (outst && cyc > exp_cyc) begin
      check("resp_missing", 32'(cyc), 32'(exp_cyc));
      outst = 1'b0;
    end
  endtask

  task automatic step();
    bit drv_if, drv_d, prev_req;
    drv_if   = if_req & ~if_flush;
    drv_d    = d_req;
    prev_req = mem_req;
    @(posedge clk);
    #1;
    cyc++;
    if (if_ready) begin if_ready_cnt++; last_if_rdata = if_rdata; last_if_err = if_err; end
    if (d_ready) begin d_ready_cnt++; last_d_rdata = d_rdata; last_d_err = d_err; end
    check("ready_exclusive", 32'(if_ready & d_ready), 32'd0);
    if (mon_en) model_step(drv_if, drv_d, prev_req);
    mem_ack   = 1'b0;
    mem_rdata = '0;
    if (mem_req) begin
      if (ack_wait == cur_lat) begin
        mem_ack = 1'b1;
        ack_cnt++;
        if (mem_we) mem[mem_addr[9:2]] = mem_wdata;
        else mem_rdata = mem[mem_addr[9:2]];
      end
      ack_wait++;
    end else begin
      ack_wait = 0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0; if_req = 1'b0; d_req = 1'b0; if_flush = 1'b0;
    step(); step();
    rst = 1'b1;
    step();
  endtask

  task automatic do_txn(input vec_t v, output logic [31:0] rd, output logic er,
                        output int ncyc, output int nreq);
    int c0, i0, d0;
    c0 = cyc; i0 = if_ready_cnt; d0 = d_ready_cnt;
    cur_lat = v.lat; nreq = 0; ncyc = -1;
    if (v.is_d) begin
      d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata; d_ubhw = 3'b010;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
    end
    for (int i = 0; i < 40; i++) begin
      step();
      if (mem_req) nreq++;
      if (v.is_d ? (d_ready_cnt != d0) : (if_ready_cnt != i0)) begin
        ncyc = cyc - c0;
        break;
      end
    end
    if_req = 1'b0; d_req = 1'b0;
    rd = v.is_d ? last_d_rdata : last_if_rdata;
    er = v.is_d ? last_d_err : last_if_err;
    step();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic er;
    int nc, nr, d_at, i_at, i0, a0, ng;
    logic [9:0] gseq;
    bit prev;

    for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + 32'(i);
    mem[16] = 32'h0050_0093;

    vecs[0] = '{1'b0, 1'b0, 32'h40,  32'h0,        1,    32'h0050_0093, 1'b0, 3,  2};
    vecs[1] = '{1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 0,    32'h0,         1'b0, 2,  1};
    vecs[2] = '{1'b1, 1'b0, 32'h100, 32'h0,        2,    32'hDEAD_BEEF, 1'b0, 4,  3};
    vecs[3] = '{1'b0, 1'b0, 32'h104, 32'h0,        15,   32'h1000_0041, 1'b0, 17, 16};
    vecs[4] = '{1'b1, 1'b0, 32'h200, 32'h0,        1000, 32'h0,         1'b1, 17, 16};
    vecs[5] = '{1'b0, 1'b0, 32'h80,  32'h0,        1000, 32'h0,         1'b1, 17, 16};
    vecs[6] = '{1'b1, 1'b0, 32'h40,  32'h0,        3,    32'h0050_0093, 1'b0, 5,  4};

    // reset state
    rst = 1'b0;
    step(); step();
    check("reset_ctrl", {27'd0, mem_req, if_ready, d_ready, owner, mem_we}, 32'd0);
    check("reset_addr", mem_addr, 32'd0);
    check("reset_rdata", if_rdata | d_rdata, 32'd0);
    check("reset_err", 32'({if_err, d_err}), 32'd0);
    rst = 1'b1;
    step();

    // directed vector table
    foreach (vecs[k]) begin
      do_txn(vecs[k], rd, er, nc, nr);
      check($sformatf("vec%0d_rdata", k), rd, vecs[k].exp_rdata);
      check($sformatf("vec%0d_err", k), 32'(er), 32'(vecs[k].exp_err));
      check($sformatf("vec%0d_latency", k), 32'(nc), 32'(vecs[k].exp_cyc));
      check($sformatf("vec%0d_memreq_cycles", k), 32'(nr), 32'(vecs[k].exp_req));
    end

    // simultaneous fetch and store: data first, fetch after
    cur_lat = 0;
    if_req = 1'b1; if_addr = 32'h40;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF; d_ubhw = 3'b010;
    step();
    check("both_owner", 32'(owner), 32'd1);
    check("both_mem_we", 32'(mem_we), 32'd1);
    check("both_mem_addr", mem_addr, 32'h100);
    check("both_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    d_at = -1; i_at = -1;
    for (int i = 0; i < 40 && i_at < 0; i++) begin
      step();
      if (d_ready) begin d_at = cyc; d_req = 1'b0; end
      if (if_ready) begin i_at = cyc; if_req = 1'b0; end
    end
    check("both_fetch_after_data", 32'(i_at > d_at && d_at > 0), 32'd1);
    check("both_fetch_rdata", last_if_rdata, 32'h0050_0093);

    // anti-starvation with both requests held continuously
    do_reset();
    cur_lat = 0; gseq = '0; ng = 0;
    if_req = 1'b1; if_addr = 32'h40;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h44;
    for (int i = 0; i < 200 && ng < 10; i++) begin
      prev = mem_req;
      step();
      if (mem_req && !prev) begin gseq = {gseq[8:0], owner}; ng++; end
    end
    if_req = 1'b0; d_req = 1'b0;
    check("starve_grant_count", 32'(ng), 32'd10);
    check("starve_grant_order", 32'(gseq), 32'(10'b1111011110));
    for (int i = 0; i < 8; i++) step();

    // fetch flushed while in ISSUE: memory completes, no if_ready
    cur_lat = 3; i0 = if_ready_cnt; a0 = ack_cnt;
    if_req = 1'b1; if_addr = 32'h44;
    step();
    check("flush_fetch_granted", 32'({mem_req, owner}), 32'b10);
    step();
    if_flush = 1'b1; if_req = 1'b0;
    step();
    if_flush = 1'b0;
    for (int i = 0; i < 10; i++) step();
    check("flush_no_if_ready", 32'(if_ready_cnt - i0), 32'd0);
    check("flush_mem_completed", 32'(ack_cnt - a0), 32'd1);
    do_txn('{1'b1, 1'b0, 32'h40, 32'h0, 0, 32'h0, 1'b0, 0, 0}, rd, er, nc, nr);
    check("flush_next_data_rdata", rd, 32'h0050_0093);
    check("flush_next_data_latency", 32'(nc), 32'd2);

    // reset while in ISSUE
    cur_lat = 1000; i0 = if_ready_cnt + d_ready_cnt;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80;
    step(); step(); step();
    check("rst_mid_in_issue", 32'(mem_req), 32'd1);
    rst = 1'b0; d_req = 1'b0;
    step();
    check("rst_mid_mem_req", 32'({mem_req, owner, d_ready}), 32'd0);
    rst = 1'b1;
    for (int i = 0; i < 20; i++) step();
    check("rst_mid_no_ready", 32'(if_ready_cnt + d_ready_cnt - i0), 32'd0);
    check("rst_mid_idle", 32'(mem_req), 32'd0);

    // randomized traffic against the transaction-level model
    do_reset();
    starve_m = 0; outst = 1'b0; nresp = 0; mon_en = 1'b1;
    for (int i = 0; i < 2500; i++) begin
      step();
      if (if_ready) if_req = 1'b0;
      if (d_ready) d_req = 1'b0;
      if (!if_req && $urandom_range(0, 2) == 0) begin
        if_req = 1'b1; if_addr = {22'd0, 8'($urandom), 2'b00};
      end
      if (!d_req && $urandom_range(0, 3) != 0) begin
        d_req = 1'b1; d_we = 1'($urandom); d_addr = {22'd0, 8'($urandom), 2'b00};
        d_wdata = $urandom; d_ubhw = 3'($urandom);
      end
    end
    mon_en = 1'b0;
    check("random_enough_responses", 32'(nresp > 100), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
